// File: rtl/slave_port_if.sv
`default_nettype none
// ============================================================================
// Module      : slave_port_if
// Description : Serial system bus plus parallel device request signals.
// Revision    : 1.0
// ============================================================================
interface slave_port_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                  mwdata;
   logic                  mmode;
   logic                  mvalid;
   logic                  srdata;
   logic                  svalid;
   logic                  sready;
   logic [ADDR_WIDTH-1:0] daddr;
   logic [DATA_WIDTH-1:0] dwdata;
   logic [DATA_WIDTH-1:0] drdata;
   logic                  dmode;
   logic                  dvalid;
   logic                  dready;

   modport slave (
      input  mwdata, mmode, mvalid, drdata, dready,
      output srdata, svalid, sready, daddr, dwdata, dmode, dvalid
   );

   modport master (
      output mwdata, mmode, mvalid, drdata, dready,
      input  srdata, svalid, sready, daddr, dwdata, dmode, dvalid
   );
endinterface
`default_nettype wire

// File: rtl/slave_port.sv
`default_nettype none
// ============================================================================
// Module      : slave_port
// Description : Serial bus target; deserialises a frame, issues one device
//               request and serialises read data back to the master.
// Revision    : 1.0
// ============================================================================
module slave_port #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rstn,
   slave_port_if.slave  bus
);
   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW    = $clog2(MAX_W + 1);
   localparam int AIW   = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
   localparam int DIW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WDATA = 3'd2,
      ST_REQ   = 3'd3,
      ST_RDATA = 3'd4
   } state_t;

   state_t                state_q,  state_d;
   logic [CW-1:0]         cnt_q,    cnt_d;
   logic [ADDR_WIDTH-1:0] daddr_q,  daddr_d;
   logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d;
   logic [DATA_WIDTH-1:0] rdreg_q,  rdreg_d;
   logic                  dmode_q,  dmode_d;
   logic                  dvalid_q, dvalid_d;
   logic                  srdata_q, srdata_d;
   logic                  svalid_q, svalid_d;
   logic                  sready_q, sready_d;
   logic [CW-1:0]         w_cnt_nxt;

   assign w_cnt_nxt = cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      daddr_d  = daddr_q;
      dwdata_d = dwdata_q;
      rdreg_d  = rdreg_q;
      dmode_d  = dmode_q;
      dvalid_d = dvalid_q;
      srdata_d = srdata_q;
      svalid_d = svalid_q;
      sready_d = sready_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.mvalid) begin
               daddr_d[0] = bus.mwdata;
               dmode_d    = bus.mmode;
               cnt_d      = CW'(1);
               state_d    = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (bus.mvalid) begin
               daddr_d[cnt_q[AIW-1:0]] = bus.mwdata;
               cnt_d = w_cnt_nxt;
               if (cnt_q == A_LAST) begin
                  cnt_d = '0;
                  if (dmode_q) begin
                     state_d = ST_WDATA;
                  end else begin
                     state_d  = ST_REQ;
                     dvalid_d = 1'b1;
                     sready_d = 1'b0;
                  end
               end
            end
         end
         ST_WDATA: begin
            if (bus.mvalid) begin
               dwdata_d[cnt_q[DIW-1:0]] = bus.mwdata;
               cnt_d = w_cnt_nxt;
               if (cnt_q == D_LAST) begin
                  cnt_d    = '0;
                  state_d  = ST_REQ;
                  dvalid_d = 1'b1;
                  sready_d = 1'b0;
               end
            end
         end
         ST_REQ: begin
            if (bus.dready) begin
               dvalid_d = 1'b0;
               if (dmode_q) begin
                  state_d  = ST_IDLE;
                  sready_d = 1'b1;
               end else begin
                  // bit 0 goes out straight from the device bus; cnt tracks the bit on srdata
                  rdreg_d  = bus.drdata;
                  srdata_d = bus.drdata[0];
                  svalid_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = ST_RDATA;
               end
            end
         end
         ST_RDATA: begin
            if (cnt_q == D_LAST) begin
               svalid_d = 1'b0;
               srdata_d = 1'b0;
               sready_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_IDLE;
            end else begin
               cnt_d    = w_cnt_nxt;
               srdata_d = rdreg_q[w_cnt_nxt[DIW-1:0]];
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         daddr_q  <= '0;
         dwdata_q <= '0;
         rdreg_q  <= '0;
         dmode_q  <= 1'b0;
         dvalid_q <= 1'b0;
         srdata_q <= 1'b0;
         svalid_q <= 1'b0;
         sready_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         daddr_q  <= daddr_d;
         dwdata_q <= dwdata_d;
         rdreg_q  <= rdreg_d;
         dmode_q  <= dmode_d;
         dvalid_q <= dvalid_d;
         srdata_q <= srdata_d;
         svalid_q <= svalid_d;
         sready_q <= sready_d;
      end
   end

   assign bus.daddr  = daddr_q;
   assign bus.dwdata = dwdata_q;
   assign bus.dmode  = dmode_q;
   assign bus.dvalid = dvalid_q;
   assign bus.srdata = srdata_q;
   assign bus.svalid = svalid_q;
   assign bus.sready = sready_q;
endmodule
`default_nettype wire
